// File: rtl/bpu_pkg.sv
// Shared branch-predictor update types and widths.
// Used by bpu_update_queue and the bimodal predictor.
package bpu_pkg;

  localparam int BPU_PC_WIDTH = 32;
  localparam int BPU_UPD_W    = BPU_PC_WIDTH + 1;

  typedef struct packed {
    logic [BPU_PC_WIDTH-1:0] pc;
    logic                    taken;
  } bpu_upd_t;

  function automatic bpu_upd_t mk_upd(
    input logic [BPU_PC_WIDTH-1:0] pc,
    input logic                    taken
  );
    bpu_upd_t u;
    u.pc    = pc;
    u.taken = taken;
    return u;
  endfunction

endpackage

// File: rtl/sync_fifo_2w1r.sv
// Pointer FIFO taking up to two in-order writes and one read per cycle.
// Pointers carry a wrap bit above the index bits.
module sync_fifo_2w1r #(
  parameter int W  = 33,
  parameter int AW = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   push_n,
  input  logic [W-1:0] wr_data0,
  input  logic [W-1:0] wr_data1,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic [AW:0]  count,
  output logic         empty,
  output logic         full
);

  localparam int DEPTH = 1 << AW;

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [AW:0]  wr_ptr1;
  logic [W-1:0] mem [DEPTH];

  assign wr_ptr1 = wr_ptr + (AW+1)'(1);
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                   (wr_ptr[AW] != rd_ptr[AW]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(push_n);
      rd_ptr <= rd_ptr + (AW+1)'(pop & ~empty);
    end
  end

  // Storage is not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (|push_n)
      mem[wr_ptr[AW-1:0]] <= wr_data0;
    if (push_n[1])
      mem[wr_ptr1[AW-1:0]] <= wr_data1;
  end

endmodule

// File: rtl/bpu_update_queue.sv
// Filters dual-commit branch outcomes and drains one update per cycle.
// Optional same-cycle bypass when idle: BPU_UPDQ_BYPASS_EN.
module bpu_update_queue
  import bpu_pkg::*;
#(
  parameter int PC_WIDTH   = BPU_PC_WIDTH,
  parameter int DEPTH_EXP2 = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            commit_valid_i,
  input  logic [1:0]            commit_is_cond_i,
  input  logic [2*PC_WIDTH-1:0] commit_pc_i,
  input  logic [1:0]            commit_taken_i,
  output logic                  commit_ready_o,
  output logic                  update_valid,
  output logic [PC_WIDTH:0]     update_instr_info,
  output logic [DEPTH_EXP2:0]   queue_count_o
);

  localparam int UW    = PC_WIDTH + 1;
  localparam int DEPTH = 1 << DEPTH_EXP2;

  logic [UW-1:0] upd0;
  logic [UW-1:0] upd1;
  logic [UW-1:0] first;
  logic [UW-1:0] wr0;
  logic [UW-1:0] rd_data;
  logic [1:0]    acc;
  logic [1:0]    push_n;
  logic          empty;
  logic          full;
  logic          byp;

  assign upd0 = {commit_pc_i[PC_WIDTH-1:0], commit_taken_i[0]};
  assign upd1 = {commit_pc_i[2*PC_WIDTH-1:PC_WIDTH],
                 commit_taken_i[1]};

  // Two free slots needed; a same-cycle pop is not credited.
  assign commit_ready_o = ~full &
    (queue_count_o != (DEPTH_EXP2+1)'(DEPTH-1));

  assign acc = commit_valid_i & commit_is_cond_i &
               {2{commit_ready_o & rst_n}};

  assign first = acc[0] ? upd0 : upd1;

`ifdef BPU_UPDQ_BYPASS_EN
  assign byp = empty & (|acc);
`else
  assign byp = 1'b0;
`endif

  always_comb begin
    push_n            = {1'b0, acc[0]} + {1'b0, acc[1]};
    wr0               = first;
    update_valid      = ~empty;
    update_instr_info = empty ? '0 : rd_data;
    if (byp) begin
      push_n            = {1'b0, acc[0] & acc[1]};
      wr0               = upd1;
      update_valid      = 1'b1;
      update_instr_info = first;
    end
  end

  sync_fifo_2w1r #(
    .W  (UW),
    .AW (DEPTH_EXP2)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_n   (push_n),
    .wr_data0 (wr0),
    .wr_data1 (upd1),
    .pop      (~empty),
    .rd_data  (rd_data),
    .count    (queue_count_o),
    .empty    (empty),
    .full     (full)
  );

endmodule

// File: tb/tb_bpu_update_queue.sv
// Directed bench for bpu_update_queue (default and bypass builds).
module tb_bpu_update_queue;
  import bpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  cv, cc, ct;
  logic [63:0] cpc;
  logic        ready, uv;
  logic [32:0] info;
  logic [3:0]  cnt;

  int cmp   = 0;
  int fails = 0;
  int cyc   = 0;

  logic [32:0] got[$];
  int          got_cyc[$];
  logic [32:0] exp[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk)
    if (uv === 1'b1) begin
      got.push_back(info);
      got_cyc.push_back(cyc);
    end

  bpu_update_queue #(
    .PC_WIDTH   (32),
    .DEPTH_EXP2 (3)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .commit_valid_i    (cv),
    .commit_is_cond_i  (cc),
    .commit_pc_i       (cpc),
    .commit_taken_i    (ct),
    .commit_ready_o    (ready),
    .update_valid      (uv),
    .update_instr_info (info),
    .queue_count_o     (cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cv  = '0;
    cc  = '0;
    ct  = '0;
    cpc = '0;
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
  endtask

  task automatic send(
    input logic [1:0]  v,
    input logic [1:0]  c,
    input logic [31:0] p0,
    input logic        t0,
    input logic [31:0] p1,
    input logic        t1
  );
    int n = 0;
    while (ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    cmp++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL send_ready: got %b want 1", ready);
    end
    cv  = v;
    cc  = c;
    cpc = {p1, p0};
    ct  = {t1, t0};
    tick();
    idle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    tick();
    rst_n = 1'b1;
    got.delete();
    got_cyc.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cv  = 2'b11;
    cc  = 2'b11;
    ct  = 2'b11;
    cpc = {32'h0000_0204, 32'h0000_0200};
    tick();
    tick();
    cmp++;
    if (uv !== 1'b0) begin
      fails++;
      $display("FAIL rst_uv: got %b want 0", uv);
    end
    cmp++;
    if (cnt !== 4'd0) begin
      fails++;
      $display("FAIL rst_cnt: got %0d want 0", cnt);
    end
    rst_n = 1'b1;
    idle();
    tick();
    cmp++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_ready: got %b want 1", ready);
    end
    cmp++;
    if (uv !== 1'b0 || info !== 33'h0) begin
      fails++;
      $display("FAIL rst_out: got %b/%h want 0/0", uv, info);
    end
    cmp++;
    if (cnt !== 4'd0) begin
      fails++;
      $display("FAIL rel_cnt: got %0d want 0", cnt);
    end
    cmp++;
    if (got.size() != 0) begin
      fails++;
      $display("FAIL rst_upd: got %0d want 0", got.size());
    end
  endtask

  task automatic test_single_push();
    logic [32:0] e;
    e = mk_upd(32'h1C00_0100, 1'b1);
    got.delete();
    cv  = 2'b01;
    cc  = 2'b01;
    ct  = 2'b01;
    cpc = {32'h0, 32'h1C00_0100};
    #1;
`ifdef BPU_UPDQ_BYPASS_EN
    cmp++;
    if (uv !== 1'b1 || info !== e) begin
      fails++;
      $display("FAIL byp_same: got %b/%h want 1/%h", uv, info, e);
    end
`else
    cmp++;
    if (uv !== 1'b0) begin
      fails++;
      $display("FAIL single_lat0: got %b want 0", uv);
    end
`endif
    tick();
    idle();
    #1;
`ifdef BPU_UPDQ_BYPASS_EN
    cmp++;
    if (uv !== 1'b0 || cnt !== 4'd0) begin
      fails++;
      $display("FAIL byp_next: got %b/%0d want 0/0", uv, cnt);
    end
`else
    cmp++;
    if (uv !== 1'b1 || info !== e || cnt !== 4'd1) begin
      fails++;
      $display("FAIL single_lat1: got %b/%h/%0d want 1/%h/1",
               uv, info, cnt, e);
    end
`endif
    drain(3);
    cmp++;
    if (got.size() != 1 || got[0] !== e) begin
      fails++;
      $display("FAIL single_data: got n=%0d %h want 1 %h",
               got.size(), got.size() ? got[0] : 33'h0, e);
    end
    cmp++;
    if (uv !== 1'b0 || cnt !== 4'd0) begin
      fails++;
      $display("FAIL single_idle: got %b/%0d want 0/0", uv, cnt);
    end
  endtask

  task automatic test_filter();
    got.delete();
    got_cyc.delete();
    send(2'b11, 2'b01, 32'h100, 1'b0, 32'h104, 1'b1);
    drain(3);
    cmp++;
    if (got.size() != 1 || got[0] !== 33'h200) begin
      fails++;
      $display("FAIL filter_one: got n=%0d %h want 1 200",
               got.size(), got.size() ? got[0] : 33'h0);
    end
    got.delete();
    got_cyc.delete();
    send(2'b11, 2'b11, 32'h100, 1'b0, 32'h104, 1'b1);
    drain(3);
    cmp++;
    if (got.size() != 2 || got[0] !== 33'h200 ||
        got[1] !== 33'h209) begin
      fails++;
      $display("FAIL filter_two: got n=%0d want 2 (200,209)",
               got.size());
    end
    cmp++;
    if (got_cyc.size() != 2 ||
        got_cyc[1] != got_cyc[0] + 1) begin
      fails++;
      $display("FAIL filter_b2b: got n=%0d want consecutive",
               got_cyc.size());
    end
  endtask

  task automatic test_fill();
    logic [31:0] p;
    got.delete();
    exp.delete();
    for (int i = 0; i < 6; i++) begin
      p = 32'h1000 + 32'(8 * i);
      send(2'b11, 2'b11, p, i[0], p + 32'h4, ~i[0]);
      exp.push_back(mk_upd(p, i[0]));
      exp.push_back(mk_upd(p + 32'h4, ~i[0]));
    end
`ifdef BPU_UPDQ_BYPASS_EN
    cmp++;
    if (cnt !== 4'd6 || ready !== 1'b1) begin
      fails++;
      $display("FAIL fill_cnt: got %0d/%b want 6/1", cnt, ready);
    end
`else
    cmp++;
    if (cnt !== 4'd7 || ready !== 1'b0) begin
      fails++;
      $display("FAIL fill_cnt: got %0d/%b want 7/0", cnt, ready);
    end
    cv  = 2'b11;
    cc  = 2'b11;
    cpc = {32'hDEAD_0004, 32'hDEAD_0000};
    tick();
    idle();
    cmp++;
    if (cnt !== 4'd6) begin
      fails++;
      $display("FAIL fill_lost: got %0d want 6", cnt);
    end
`endif
    drain(14);
    cmp++;
    if (got.size() != exp.size()) begin
      fails++;
      $display("FAIL fill_n: got %0d want %0d",
               got.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      cmp++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        fails++;
        $display("FAIL fill_ord[%0d]: got %h want %h", i,
                 i < got.size() ? got[i] : 33'h0, exp[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] p;
    do_reset();
    exp.delete();
    for (int k = 0; k < 5; k++) begin
      p = 32'h2000 + 32'(4 * k);
      if (k[0])
        send(2'b10, 2'b11, 32'hBAD0, 1'b0, p, k[1]);
      else
        send(2'b01, 2'b11, p, k[1], 32'hBAD4, 1'b1);
      exp.push_back(mk_upd(p, k[1]));
    end
    for (int i = 0; i < 6; i++) begin
      p = 32'h3000 + 32'(8 * i);
      send(2'b11, 2'b11, p, ~i[0], p + 32'h4, i[1]);
      exp.push_back(mk_upd(p, ~i[0]));
      exp.push_back(mk_upd(p + 32'h4, i[1]));
    end
`ifndef BPU_UPDQ_BYPASS_EN
    cmp++;
    if (cnt !== 4'd7 || ready !== 1'b0) begin
      fails++;
      $display("FAIL wrap_cnt: got %0d/%b want 7/0", cnt, ready);
    end
`endif
    drain(20);
    cmp++;
    if (got.size() != exp.size()) begin
      fails++;
      $display("FAIL wrap_n: got %0d want %0d",
               got.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      cmp++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        fails++;
        $display("FAIL wrap_ord[%0d]: got %h want %h", i,
                 i < got.size() ? got[i] : 33'h0, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] p;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      p = 32'h4000 + 32'(8 * i);
      send(2'b11, 2'b11, p, 1'b1, p + 32'h4, 1'b0);
    end
    cmp++;
`ifdef BPU_UPDQ_BYPASS_EN
    if (cnt !== 4'd4) begin
      fails++;
      $display("FAIL mid_pre: got %0d want 4", cnt);
    end
`else
    if (cnt !== 4'd5) begin
      fails++;
      $display("FAIL mid_pre: got %0d want 5", cnt);
    end
`endif
    rst_n = 1'b0;
    tick();
    got.delete();
    cmp++;
    if (cnt !== 4'd0 || uv !== 1'b0) begin
      fails++;
      $display("FAIL mid_rst: got %0d/%b want 0/0", cnt, uv);
    end
    rst_n = 1'b1;
    drain(4);
    cmp++;
    if (got.size() != 0 || cnt !== 4'd0 || ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_after: got n=%0d cnt=%0d rdy=%b want 0/0/1",
               got.size(), cnt, ready);
    end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_filter();
    test_fill();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp, fails);
    $finish;
  end

endmodule
